// File: rtl/dpgen.sv
// ---------------------------------------------------------------------------
// dpgen : 8x8 Conway's Game of Life datapath / generator
//
// Holds a 64-cell grid in a register. While idle the grid continuously
// loads the incoming pattern; once started it advances one generation per
// clock for as long as start is held, freezing when start drops.
//
// Cell mapping: bit index = row*8 + col, so byte k is row k and bit 0 of a
// row is column 0. A 1 is a live cell. The grid does not wrap: cells
// outside the 8x8 area count as dead.
//
// Ports:
//   clk    in   1  rising-edge clock
//   reset  in   1  asynchronous reset, active low (0 = reset asserted)
//   gin    in  64  initial pattern, sampled every edge while idle
//   clear  in   1  synchronous grid clear, active high, beats start
//   start  in   1  run enable, level sensitive
//   gout   out 64  current grid, straight from the grid register
// ---------------------------------------------------------------------------
module dpgen (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] gin,
  input  logic        clear,
  input  logic        start,
  output logic [63:0] gout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [63:0] grid, grid_d;
  logic [63:0] next_gen;
  logic [3:0]  count;
  logic [5:0]  idx;

  // Next generation for all 64 cells in parallel. Neighbours that fall
  // outside the grid are skipped, which is what makes edges and corners
  // see only 5 and 3 neighbours.
  always_comb begin
    next_gen = '0;
    count    = '0;
    idx      = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        count = '0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0) &&
                (r + dr >= 0) && (r + dr < 8) &&
                (c + dc >= 0) && (c + dc < 8)) begin
              idx   = 6'(((r + dr) * 8) + (c + dc));
              count = count + {3'b000, grid[idx]};
            end
          end
        end
        idx = 6'((r * 8) + c);
        next_gen[idx] = (count == 4'd3) || (grid[idx] && (count == 4'd2));
      end
    end
  end

  // State register. Reset always returns to IDLE, which is the only way
  // back there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic. An X start in IDLE evaluates false and keeps the
  // block idle rather than launching a run on garbage.
  always_comb begin
    state_d = state;
    if (clear) begin
      state_d = PAUSE;
    end else begin
      case (state)
        IDLE:    if (start)  state_d = RUN;
        RUN:     if (!start) state_d = PAUSE;
        PAUSE:   if (start)  state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Grid update selection. The edge that leaves IDLE still loads gin, and
  // the edge that drops out of RUN does not advance the grid.
  always_comb begin
    grid_d = grid;
    if (clear) begin
      grid_d = '0;
    end else begin
      case (state)
        IDLE:    grid_d = gin;
        RUN:     if (start) grid_d = next_gen;
        default: grid_d = grid;
      endcase
    end
  end

  // Grid register; gout is driven directly from it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) grid <= '0;
    else        grid <= grid_d;
  end

  assign gout = grid;

endmodule

// File: tb/tb_dpgen.sv
// ---------------------------------------------------------------------------
// tb_dpgen : self-checking bench for dpgen
//
// Inputs change on the falling clock edge; gout is sampled 1 time unit after
// the rising edge. Each scenario pushes the value it expects onto a queue
// before the edge and pops it for comparison once the edge has passed.
// ---------------------------------------------------------------------------
module tb_dpgen;

  logic        clk;
  logic        reset;
  logic [63:0] gin;
  logic        clear;
  logic        start;
  logic [63:0] gout;

  int total_checks;
  int passed_checks;

  logic [63:0] exp_q[$];
  logic [63:0] e;

  localparam logic [63:0] LOAD_PAT  = 64'h0412_6424_0034_3C28;
  localparam logic [63:0] BLINK_H   = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINK_V   = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLOCK     = 64'h0000_0018_1800_0000;
  localparam logic [63:0] CORNER_L  = 64'h0000_0000_0000_0103;
  localparam logic [63:0] CORNER_B  = 64'h0000_0000_0000_0303;
  localparam logic [63:0] EDGE_MASK = 64'hFF80_8080_8080_8080;

  dpgen dut (
    .clk   (clk),
    .reset (reset),
    .gin   (gin),
    .clear (clear),
    .start (start),
    .gout  (gout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset the block with a new pattern on gin, release reset mid-cycle.
  task automatic reset_with(input logic [63:0] pat);
    @(negedge clk);
    reset = 1'b0;
    clear = 1'b0;
    start = 1'b0;
    gin   = pat;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    clear = 1'b0;
    start = 1'b0;
    gin   = LOAD_PAT;
    #1;
    total_checks++;
    if (gout !== 64'h0) $display("[TB] FAIL reset_async: gout=%h expected=%h", gout, 64'h0);
    else passed_checks++;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(64'h0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total_checks++;
      if (gout !== e) $display("[TB] FAIL reset_held: gout=%h expected=%h", gout, e);
      else passed_checks++;
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(LOAD_PAT);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total_checks++;
      if (gout !== e) $display("[TB] FAIL reset_load: gout=%h expected=%h", gout, e);
      else passed_checks++;
    end
  endtask

  // An undriven start while idle must not launch a run; gout keeps tracking gin.
  task automatic test_x_start();
    @(negedge clk);
    start = 1'bx;
    gin   = BLOCK;
    exp_q.push_back(BLOCK);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total_checks++;
    if (gout !== e) $display("[TB] FAIL x_start_load1: gout=%h expected=%h", gout, e);
    else passed_checks++;
    @(negedge clk);
    gin = BLINK_H;
    exp_q.push_back(BLINK_H);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total_checks++;
    if (gout !== e) $display("[TB] FAIL x_start_idle: gout=%h expected=%h", gout, e);
    else passed_checks++;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_blinker();
    reset_with(BLINK_H);
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(BLINK_H);
    for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? BLINK_V : BLINK_H);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total_checks++;
      if (gout !== e) $display("[TB] FAIL blinker[%0d]: gout=%h expected=%h", i, gout, e);
      else passed_checks++;
    end
  endtask

  task automatic test_block();
    reset_with(BLOCK);
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 11; i++) exp_q.push_back(BLOCK);
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total_checks++;
      if (gout !== e) $display("[TB] FAIL block[%0d]: gout=%h expected=%h", i, gout, e);
      else passed_checks++;
    end
  endtask

  task automatic test_corner();
    reset_with(CORNER_L);
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(CORNER_L);
    for (int i = 0; i < 4; i++) exp_q.push_back(CORNER_B);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total_checks++;
      if (gout !== e) $display("[TB] FAIL corner[%0d]: gout=%h expected=%h", i, gout, e);
      else passed_checks++;
      total_checks++;
      if ((gout & EDGE_MASK) !== 64'h0)
        $display("[TB] FAIL corner_nowrap[%0d]: row7/col7 bits=%h expected=%h", i, gout & EDGE_MASK, 64'h0);
      else passed_checks++;
    end
  endtask

  task automatic test_pause_clear();
    logic [63:0] held;
    reset_with(BLINK_H);
    @(negedge clk);
    start = 1'b1;
    // Load edge then three generations: H, V, H, V.
    for (int i = 0; i < 4; i++) exp_q.push_back((i % 2 == 0) ? BLINK_H : BLINK_V);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total_checks++;
      if (gout !== e) $display("[TB] FAIL pause_run[%0d]: gout=%h expected=%h", i, gout, e);
      else passed_checks++;
    end
    held = BLINK_V;
    // Dropping start freezes the grid from that edge onward.
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back(held);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total_checks++;
      if (gout !== e) $display("[TB] FAIL pause_hold[%0d]: gout=%h expected=%h", i, gout, e);
      else passed_checks++;
    end
    // Resuming: first edge only re-enters RUN, then alternation continues.
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(BLINK_V);
    exp_q.push_back(BLINK_H);
    exp_q.push_back(BLINK_V);
    exp_q.push_back(BLINK_H);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total_checks++;
      if (gout !== e) $display("[TB] FAIL pause_resume[%0d]: gout=%h expected=%h", i, gout, e);
      else passed_checks++;
    end
    // Clear beats start and the empty grid stays empty while running.
    @(negedge clk);
    clear = 1'b1;
    exp_q.push_back(64'h0);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total_checks++;
    if (gout !== e) $display("[TB] FAIL clear: gout=%h expected=%h", gout, e);
    else passed_checks++;
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(64'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total_checks++;
      if (gout !== e) $display("[TB] FAIL clear_stays[%0d]: gout=%h expected=%h", i, gout, e);
      else passed_checks++;
    end
  endtask

  task automatic test_async_reset();
    reset_with(BLINK_H);
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(BLINK_H);
    exp_q.push_back(BLINK_V);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total_checks++;
      if (gout !== e) $display("[TB] FAIL async_prerun[%0d]: gout=%h expected=%h", i, gout, e);
      else passed_checks++;
    end
    // Assert reset between edges and look before any clock edge arrives.
    #2;
    reset = 1'b0;
    #1;
    total_checks++;
    if (gout !== 64'h0) $display("[TB] FAIL async_reset_now: gout=%h expected=%h", gout, 64'h0);
    else passed_checks++;
    gin = LOAD_PAT;
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    exp_q.push_back(LOAD_PAT);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total_checks++;
    if (gout !== e) $display("[TB] FAIL async_reload: gout=%h expected=%h", gout, e);
    else passed_checks++;
    // Still idle: gout follows a new gin.
    @(negedge clk);
    gin = CORNER_L;
    exp_q.push_back(CORNER_L);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total_checks++;
    if (gout !== e) $display("[TB] FAIL async_idle_track: gout=%h expected=%h", gout, e);
    else passed_checks++;
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    reset = 1'b0;
    clear = 1'b0;
    start = 1'b0;
    gin   = '0;
    test_reset();
    test_x_start();
    test_blinker();
    test_block();
    test_corner();
    test_pause_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
